// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and load/store.
// One transaction in flight; load/store wins unless fetch has been starved too long.
module mem_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            hlt,
  input  logic            flush,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [2:0]      d_size,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  output logic            m_req,
  output logic            m_we,
  output logic [2:0]      m_size,
  output logic [XLEN-1:0] m_addr,
  output logic [XLEN-1:0] m_wdata,
  input  logic            m_gnt,
  input  logic            m_rvalid,
  input  logic [XLEN-1:0] m_rdata
);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  localparam logic [CNT_W-1:0] LIMIT     = CNT_W'(STARVE_LIMIT);
  localparam logic [2:0]       SIZE_WORD = 3'b010;

  state_t           state_reg, state_next;
  owner_t           owner_reg, owner_next;
  logic             drop_reg, drop_next;
  logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;

  logic if_ok, starved, sel_if, sel_d;
  logic rsp_if, rsp_d;

  // Idle-time winner selection; starvation overrides load/store priority.
  always_comb begin
    if_ok   = if_req & ~hlt;
    starved = if_ok & (starve_cnt_reg == LIMIT);
    sel_if  = starved | (if_ok & ~d_req);
    sel_d   = d_req & ~starved;
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    drop_next       = drop_reg;
    starve_cnt_next = starve_cnt_reg;
    m_req           = 1'b0;
    m_we            = 1'b0;
    m_size          = 3'b000;
    m_addr          = '0;
    m_wdata         = '0;
    if_gnt          = 1'b0;
    d_gnt           = 1'b0;
    rsp_if          = 1'b0;
    rsp_d           = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        m_req = ~reset & (sel_if | sel_d);
        if (sel_d) begin
          m_we    = d_we;
          m_size  = d_size;
          m_addr  = d_addr;
          m_wdata = d_wdata;
        end else if (sel_if) begin
          m_size  = SIZE_WORD;
          m_addr  = if_addr;
        end
        if_gnt = m_req & m_gnt & sel_if;
        d_gnt  = m_req & m_gnt & sel_d;

        if (if_gnt || d_gnt) begin
          state_next = ST_BUSY;
          owner_next = d_gnt ? OWN_D : OWN_IF;
        end

        if (d_gnt && if_ok) begin
          starve_cnt_next = (starve_cnt_reg == LIMIT) ? LIMIT : starve_cnt_reg + CNT_W'(1);
        end else if (if_gnt || !if_ok) begin
          starve_cnt_next = '0;
        end

        // A redirect in the grant cycle already makes this fetch stale.
        if (if_gnt && flush) begin
          drop_next = 1'b1;
        end
      end

      ST_BUSY: begin
        if (m_rvalid) begin
          state_next = ST_IDLE;
          drop_next  = 1'b0;
          rsp_d      = ~reset & (owner_reg == OWN_D);
          rsp_if     = ~reset & (owner_reg == OWN_IF) & ~drop_reg & ~flush;
        end else if (flush && owner_reg == OWN_IF) begin
          drop_next = 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      owner_reg      <= OWN_IF;
      drop_reg       <= 1'b0;
      starve_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      drop_reg       <= drop_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  assign if_rvalid = rsp_if;
  assign d_rvalid  = rsp_d;

  // Read data reaches only the requester that owns the response.
  generate
    for (genvar gi = 0; gi < XLEN; gi++) begin : g_rdata
      assign if_rdata[gi] = m_rdata[gi] & rsp_if;
      assign d_rdata[gi]  = m_rdata[gi] & rsp_d;
    end
  endgenerate

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run against a transaction-level arbitration model and a simple memory.
module tb_mem_port_arbiter;

  localparam int XLEN  = 32;
  localparam int LIMIT = 4;

  logic            clk = 1'b0;
  logic            reset, hlt, flush;
  logic            if_req, if_gnt, if_rvalid;
  logic [XLEN-1:0] if_addr, if_rdata;
  logic            d_req, d_we, d_gnt, d_rvalid;
  logic [2:0]      d_size, m_size;
  logic [XLEN-1:0] d_addr, d_wdata, d_rdata;
  logic            m_req, m_we, m_gnt, m_rvalid;
  logic [XLEN-1:0] m_addr, m_wdata, m_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .hlt(hlt), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  // {m_req, if_gnt, d_gnt, if_rvalid, d_rvalid}
  function automatic logic [4:0] ctl();
    return {m_req, if_gnt, d_gnt, if_rvalid, d_rvalid};
  endfunction

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic idle_in();
    hlt = 1'b0; flush = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_size = 3'b000; d_addr = '0; d_wdata = '0;
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; if_req = 1'b1; d_req = 1'b1; m_gnt = 1'b1; m_rvalid = 1'b1;
    #1;
    n_tests++;
    if (ctl() !== 5'b00000) begin n_fail++; $display("FAIL reset_active: ctl=%b want 00000", ctl()); end
    @(negedge clk);
    idle_in(); reset = 1'b0;
    #1;
    n_tests++;
    if (ctl() !== 5'b00000) begin n_fail++; $display("FAIL reset_released: ctl=%b want 00000", ctl()); end
  endtask

  task automatic test_if_only();
    @(negedge clk); idle_in(); if_req = 1'b1; if_addr = 32'h0; #1;
    n_tests++;
    if (ctl() !== 5'b10000) begin n_fail++; $display("FAIL t1_stall: ctl=%b want 10000", ctl()); end
    @(negedge clk); m_gnt = 1'b1; #1;
    n_tests++;
    if (ctl() !== 5'b11000 || m_addr !== 32'h0 || m_we !== 1'b0 || m_size !== 3'b010 || m_wdata !== 32'h0) begin
      n_fail++; $display("FAIL t1_gnt_c0: ctl=%b we=%b size=%b addr=%h want 11000 0 010 00000000", ctl(), m_we, m_size, m_addr);
    end
    @(negedge clk); m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0000_0013; if_addr = 32'h4; #1;
    n_tests++;
    if (ctl() !== 5'b00010 || if_rdata !== 32'h0000_0013) begin
      n_fail++; $display("FAIL t1_rvalid_c1: ctl=%b data=%h want 00010 00000013", ctl(), if_rdata);
    end
    @(negedge clk); m_rvalid = 1'b0; m_gnt = 1'b1; #1;
    n_tests++;
    if (ctl() !== 5'b11000 || m_addr !== 32'h4) begin
      n_fail++; $display("FAIL t1_gnt_c2: ctl=%b addr=%h want 11000 00000004", ctl(), m_addr);
    end
    @(negedge clk); m_gnt = 1'b0; if_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h00A0_0093; #1;
    n_tests++;
    if (ctl() !== 5'b00010 || if_rdata !== 32'h00A0_0093) begin
      n_fail++; $display("FAIL t1_rvalid_c3: ctl=%b data=%h want 00010 00a00093", ctl(), if_rdata);
    end
    @(negedge clk); idle_in();
  endtask

  task automatic test_starvation();
    logic        exp_if;
    logic [31:0] exp_addr, got_data;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h200; d_req = 1'b1; d_we = 1'b0; d_size = 3'b010;
      d_addr = 32'h1000 + 32'(k * 4); m_gnt = 1'b1; m_rvalid = 1'b0;
      #1;
      exp_if   = (k == LIMIT);
      exp_addr = exp_if ? 32'h200 : 32'h1000 + 32'(k * 4);
      n_tests++;
      if ({if_gnt, d_gnt} !== {exp_if, ~exp_if} || m_addr !== exp_addr) begin
        n_fail++; $display("FAIL t2_grant_%0d: if_gnt=%b d_gnt=%b addr=%h want %b %b %h", k, if_gnt, d_gnt, m_addr, exp_if, ~exp_if, exp_addr);
      end
      @(negedge clk); m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hA000 + 32'(k); #1;
      got_data = exp_if ? if_rdata : d_rdata;
      n_tests++;
      if ({if_rvalid, d_rvalid} !== {exp_if, ~exp_if} || got_data !== 32'hA000 + 32'(k)) begin
        n_fail++; $display("FAIL t2_resp_%0d: if_rvalid=%b d_rvalid=%b data=%h want %b %b %h", k, if_rvalid, d_rvalid, got_data, exp_if, ~exp_if, 32'hA000 + 32'(k));
      end
    end
    @(negedge clk); idle_in();
  endtask

  task automatic test_store();
    @(negedge clk); idle_in();
    d_req = 1'b1; d_we = 1'b1; d_size = 3'b000; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; m_gnt = 1'b1;
    #1;
    n_tests++;
    if (ctl() !== 5'b10100 || m_we !== 1'b1 || m_size !== 3'b000 || m_addr !== 32'h100 || m_wdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL t3_store_req: ctl=%b we=%b size=%b addr=%h wdata=%h want 10100 1 000 00000100 deadbeef", ctl(), m_we, m_size, m_addr, m_wdata);
    end
    @(negedge clk); d_req = 1'b0; d_we = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b1; #1;
    n_tests++;
    if (ctl() !== 5'b00001) begin n_fail++; $display("FAIL t3_store_ack: ctl=%b want 00001", ctl()); end
    @(negedge clk); idle_in();
  endtask

  task automatic test_flush();
    // fetch in flight, flush, response three cycles later
    @(negedge clk); idle_in(); if_req = 1'b1; if_addr = 32'h300; m_gnt = 1'b1; #1;
    n_tests++;
    if (ctl() !== 5'b11000) begin n_fail++; $display("FAIL t4_gnt: ctl=%b want 11000", ctl()); end
    @(negedge clk); if_req = 1'b0; m_gnt = 1'b0; flush = 1'b1; #1;
    n_tests++;
    if (ctl() !== 5'b00000) begin n_fail++; $display("FAIL t4_busy: ctl=%b want 00000", ctl()); end
    @(negedge clk); flush = 1'b0;
    @(negedge clk);
    @(negedge clk); m_rvalid = 1'b1; m_rdata = 32'h1111_1111; #1;
    n_tests++;
    if (ctl() !== 5'b00000) begin n_fail++; $display("FAIL t4_dropped: ctl=%b want 00000", ctl()); end
    @(negedge clk); m_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h304; m_gnt = 1'b1; #1;
    n_tests++;
    if (ctl() !== 5'b11000) begin n_fail++; $display("FAIL t4_regrant: ctl=%b want 11000", ctl()); end
    @(negedge clk); if_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h2222_2222; #1;
    n_tests++;
    if (ctl() !== 5'b00010 || if_rdata !== 32'h2222_2222) begin
      n_fail++; $display("FAIL t4_after_drop: ctl=%b data=%h want 00010 22222222", ctl(), if_rdata);
    end
    // flush in the grant cycle
    @(negedge clk); m_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h308; m_gnt = 1'b1; flush = 1'b1; #1;
    n_tests++;
    if (ctl() !== 5'b11000) begin n_fail++; $display("FAIL t4_gnt_flush: ctl=%b want 11000", ctl()); end
    @(negedge clk); if_req = 1'b0; m_gnt = 1'b0; flush = 1'b0; m_rvalid = 1'b1; #1;
    n_tests++;
    if (ctl() !== 5'b00000) begin n_fail++; $display("FAIL t4_gnt_flush_drop: ctl=%b want 00000", ctl()); end
    // flush coincident with the response, then a clean fetch
    @(negedge clk); m_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h30C; m_gnt = 1'b1;
    @(negedge clk); if_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b1; flush = 1'b1; #1;
    n_tests++;
    if (ctl() !== 5'b00000) begin n_fail++; $display("FAIL t4_flush_rsp: ctl=%b want 00000", ctl()); end
    @(negedge clk); flush = 1'b0; m_rvalid = 1'b0; if_req = 1'b1; m_gnt = 1'b1;
    @(negedge clk); if_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h3333_3333; #1;
    n_tests++;
    if (ctl() !== 5'b00010 || if_rdata !== 32'h3333_3333) begin
      n_fail++; $display("FAIL t4_drop_cleared: ctl=%b data=%h want 00010 33333333", ctl(), if_rdata);
    end
    // flush while load/store owns the port
    @(negedge clk); m_rvalid = 1'b0; d_req = 1'b1; d_addr = 32'h400; m_gnt = 1'b1;
    @(negedge clk); d_req = 1'b0; m_gnt = 1'b0; flush = 1'b1;
    @(negedge clk); flush = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h4444_4444; #1;
    n_tests++;
    if (ctl() !== 5'b00001 || d_rdata !== 32'h4444_4444) begin
      n_fail++; $display("FAIL t4_flush_d: ctl=%b data=%h want 00001 44444444", ctl(), d_rdata);
    end
    // flush in idle without a grant is ignored
    @(negedge clk); m_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h310; flush = 1'b1; m_gnt = 1'b0; #1;
    n_tests++;
    if (ctl() !== 5'b10000) begin n_fail++; $display("FAIL t4_idle_flush: ctl=%b want 10000", ctl()); end
    @(negedge clk); flush = 1'b0; m_gnt = 1'b1;
    @(negedge clk); if_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h5555_5555; #1;
    n_tests++;
    if (ctl() !== 5'b00010 || if_rdata !== 32'h5555_5555) begin
      n_fail++; $display("FAIL t4_idle_flush_rsp: ctl=%b data=%h want 00010 55555555", ctl(), if_rdata);
    end
    @(negedge clk); idle_in();
  endtask

  task automatic test_hlt();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); hlt = 1'b1; if_req = 1'b1; if_addr = 32'h500; m_gnt = 1'b1; #1;
      n_tests++;
      if (ctl() !== 5'b00000) begin n_fail++; $display("FAIL t5_hlt_cycle_%0d: ctl=%b want 00000", i, ctl()); end
    end
    @(negedge clk); d_req = 1'b1; d_addr = 32'h600; #1;
    n_tests++;
    if (ctl() !== 5'b10100 || m_addr !== 32'h600) begin
      n_fail++; $display("FAIL t5_d_under_hlt: ctl=%b addr=%h want 10100 00000600", ctl(), m_addr);
    end
    @(negedge clk); d_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b1; #1;
    n_tests++;
    if (ctl() !== 5'b00001) begin n_fail++; $display("FAIL t5_d_rsp: ctl=%b want 00001", ctl()); end
    @(negedge clk); m_rvalid = 1'b0; hlt = 1'b0; m_gnt = 1'b1; #1;
    n_tests++;
    if (ctl() !== 5'b11000 || m_addr !== 32'h500) begin
      n_fail++; $display("FAIL t5_if_gnt: ctl=%b addr=%h want 11000 00000500", ctl(), m_addr);
    end
    @(negedge clk); hlt = 1'b1; if_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h6666_6666; #1;
    n_tests++;
    if (ctl() !== 5'b00010 || if_rdata !== 32'h6666_6666) begin
      n_fail++; $display("FAIL t5_inflight: ctl=%b data=%h want 00010 66666666", ctl(), if_rdata);
    end
    @(negedge clk); idle_in();
  endtask

  task automatic test_reset_busy();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h700; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h800 + 32'(k * 4);
      m_gnt = 1'b1; m_rvalid = 1'b0;
      #1;
      n_tests++;
      if (ctl() !== 5'b10100) begin n_fail++; $display("FAIL t6_d_gnt_%0d: ctl=%b want 10100", k, ctl()); end
      if (k < 3) begin
        @(negedge clk); m_gnt = 1'b0; m_rvalid = 1'b1; #1;
        n_tests++;
        if (ctl() !== 5'b00001) begin n_fail++; $display("FAIL t6_d_rsp_%0d: ctl=%b want 00001", k, ctl()); end
      end
    end
    @(negedge clk); reset = 1'b1; m_gnt = 1'b1; m_rvalid = 1'b1; #1;
    n_tests++;
    if (ctl() !== 5'b00000) begin n_fail++; $display("FAIL t6_reset_cycle: ctl=%b want 00000", ctl()); end
    @(negedge clk); reset = 1'b0; m_rvalid = 1'b0; m_gnt = 1'b0; d_addr = 32'h900; #1;
    n_tests++;
    if (ctl() !== 5'b10000 || m_addr !== 32'h900) begin
      n_fail++; $display("FAIL t6_idle_after: ctl=%b addr=%h want 10000 00000900", ctl(), m_addr);
    end
    @(negedge clk); m_gnt = 1'b1; #1;
    n_tests++;
    if (ctl() !== 5'b10100) begin n_fail++; $display("FAIL t6_cnt_cleared: ctl=%b want 10100", ctl()); end
    @(negedge clk); if_req = 1'b0; d_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b1; #1;
    n_tests++;
    if (ctl() !== 5'b00001) begin n_fail++; $display("FAIL t6_final_rsp: ctl=%b want 00001", ctl()); end
    @(negedge clk); idle_in();
  endtask

  task automatic test_random();
    logic        busy, own_d, txn_we, dropped, if_ok, pick_if, pick_d, if_acc, d_acc, mem_pend;
    int          bypass, mem_delay;
    logic [31:0] txn_addr, mem_addr;
    logic [4:0]  exp;
    logic [67:0] exp_m;
    busy = 1'b0; own_d = 1'b0; txn_we = 1'b0; dropped = 1'b0; if_acc = 1'b0; d_acc = 1'b0;
    mem_pend = 1'b0; bypass = 0; mem_delay = 0; txn_addr = '0; mem_addr = '0;
    @(negedge clk); idle_in(); reset = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset = 1'b0;
      if (!if_req || if_acc) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = 32'($urandom_range(0, 255)) << 2;
      end
      if (!d_req || d_acc) begin
        d_req   = ($urandom_range(0, 2) == 0);
        d_we    = 1'($urandom_range(0, 1));
        d_size  = 3'($urandom_range(0, 7));
        d_addr  = 32'h8000 | (32'($urandom_range(0, 255)) << 2);
        d_wdata = $urandom;
      end
      hlt      = ($urandom_range(0, 7) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      m_gnt    = 1'($urandom_range(0, 1));
      m_rvalid = 1'b0;
      m_rdata  = $urandom;
      if (mem_pend) begin
        if (mem_delay == 0) begin
          m_rvalid = 1'b1;
          m_rdata  = mdata(mem_addr);
        end else begin
          mem_delay--;
        end
      end
      #1;
      exp     = 5'b00000;
      pick_if = 1'b0;
      pick_d  = 1'b0;
      if_ok   = if_req & ~hlt;
      if (!busy) begin
        pick_if = if_ok && (bypass >= LIMIT || !d_req);
        pick_d  = d_req && !pick_if;
        exp     = {pick_if | pick_d, pick_if & m_gnt, pick_d & m_gnt, 2'b00};
      end else if (m_rvalid) begin
        exp = {3'b000, !own_d && !dropped && !flush, own_d};
      end
      n_tests++;
      if (ctl() !== exp) begin
        n_fail++; $display("FAIL rnd_ctl cycle %0d: ctl=%b want %b", c, ctl(), exp);
      end
      if (pick_if || pick_d) begin
        exp_m = pick_d ? {d_we, d_size, d_addr, d_wdata} : {1'b0, 3'b010, if_addr, 32'h0};
        n_tests++;
        if ({m_we, m_size, m_addr, m_wdata} !== exp_m) begin
          n_fail++; $display("FAIL rnd_mux cycle %0d: got %h want %h", c, {m_we, m_size, m_addr, m_wdata}, exp_m);
        end
      end
      if (busy && m_rvalid && !own_d && !dropped && !flush) begin
        n_tests++;
        if (if_rdata !== mdata(txn_addr)) begin
          n_fail++; $display("FAIL rnd_if_data cycle %0d: got %h want %h", c, if_rdata, mdata(txn_addr));
        end
      end
      if (busy && m_rvalid && own_d && !txn_we) begin
        n_tests++;
        if (d_rdata !== mdata(txn_addr)) begin
          n_fail++; $display("FAIL rnd_d_data cycle %0d: got %h want %h", c, d_rdata, mdata(txn_addr));
        end
      end
      // requesters and memory react to the handshakes they actually saw
      if_acc = if_gnt;
      d_acc  = d_gnt;
      if (m_rvalid) mem_pend = 1'b0;
      if (m_req && m_gnt && !mem_pend) begin
        mem_pend  = 1'b1;
        mem_addr  = m_addr;
        mem_delay = int'($urandom_range(0, 3));
      end
      // reference arbitration state advances on the coming edge
      if (!busy) begin
        if (pick_d && m_gnt) bypass = if_ok ? ((bypass < LIMIT) ? bypass + 1 : LIMIT) : 0;
        else if ((pick_if && m_gnt) || !if_ok) bypass = 0;
        if ((pick_if || pick_d) && m_gnt) begin
          busy     = 1'b1;
          own_d    = pick_d;
          txn_we   = pick_d & d_we;
          txn_addr = pick_d ? d_addr : if_addr;
          dropped  = pick_if & flush;
        end
      end else if (m_rvalid) begin
        busy    = 1'b0;
        dropped = 1'b0;
      end else if (flush && !own_d) begin
        dropped = 1'b1;
      end
    end
    @(negedge clk); idle_in();
  endtask

  initial begin
    reset = 1'b1;
    idle_in();
    test_reset();
    test_if_only();
    test_starvation();
    test_store();
    test_flush();
    test_hlt();
    test_reset_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1, "bench timeout");
  end

endmodule
